// File: rtl/vectorops_pkg.sv
// Shared types and saturation helpers for the N-channel vector engine.
package vectorops_pkg;

  typedef enum logic [1:0] {
    MODE_SUM = 2'b00,
    MODE_SUB = 2'b01,
    MODE_MAX = 2'b10
  } mode_t;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) << (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO; dout reads as zero while empty.
module fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AddrWidth = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AddrWidth:0] wr_ptr_q, rd_ptr_q;
  logic               do_write, do_read;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
               (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);
    do_write = wr_en && !full;
    do_read  = rd_en && !empty;
    dout     = empty ? '0 : mem[rd_ptr_q[AddrWidth-1:0]];
  end

  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[wr_ptr_q[AddrWidth-1:0]] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_read)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/vectorops_core.sv
// Fire logic, wide reduction, narrowing, result register and result counter.
// Build option: VECTOROPS_SAT_EN clamps out-of-range results instead of wrapping.
module vectorops_core
  import vectorops_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_rd_en,
  input  logic [1:0]                   mode,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [COUNT_WIDTH-1:0]       result_count
);

  localparam int unsigned WideWidth = DATA_WIDTH + $clog2(NUM_IN) + 1;

  state_t                       state_q, state_d;
  logic                         res_valid, fire;
  logic [DATA_WIDTH-1:0]        res_q, narrowed;
  logic [COUNT_WIDTH-1:0]       count_q;
  logic signed [WideWidth-1:0]  acc_sum, acc_sub, acc_max, opnd, wide;

  function automatic logic signed [WideWidth-1:0] sext(input logic [DATA_WIDTH-1:0] w);
    return {{(WideWidth - DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
  endfunction

  always_comb begin
    opnd    = '0;
    acc_sum = sext(in_data[DATA_WIDTH-1:0]);
    acc_sub = acc_sum;
    acc_max = acc_sum;
    for (int k = 1; k < int'(NUM_IN); k++) begin
      opnd    = sext(in_data[k*DATA_WIDTH +: DATA_WIDTH]);
      acc_sum = acc_sum + opnd;
      acc_sub = acc_sub - opnd;
      if (opnd > acc_max) acc_max = opnd;
    end
    case (mode_t'(mode))
      MODE_SUB: wide = acc_sub;
      MODE_MAX: wide = acc_max;
      default:  wide = acc_sum;
    endcase
  end

`ifdef VECTOROPS_SAT_EN
  localparam logic signed [WideWidth-1:0] SatHi = WideWidth'(sat_max(DATA_WIDTH));
  localparam logic signed [WideWidth-1:0] SatLo = WideWidth'(sat_min(DATA_WIDTH));

  // Max of in-range operands is always in range, so clamping it is a no-op.
  always_comb begin
    if (wide > SatHi) begin
      narrowed = SatHi[DATA_WIDTH-1:0];
    end else if (wide < SatLo) begin
      narrowed = SatLo[DATA_WIDTH-1:0];
    end else begin
      narrowed = wide[DATA_WIDTH-1:0];
    end
  end
`else
  logic unused_wide_hi;
  assign unused_wide_hi = ^wide[WideWidth-1:DATA_WIDTH];

  always_comb begin
    narrowed = wide[DATA_WIDTH-1:0];
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (fire) state_d = S_FULL;
      S_FULL:  if (out_wr_en && !fire) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // All channels pop together so pairing stays strictly by arrival order.
  always_comb begin
    res_valid = (state_q == S_FULL);
    out_wr_en = res_valid && !out_full;
    fire      = (&(~in_empty)) && (!res_valid || !out_full);
    in_rd_en  = {NUM_IN{fire}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q   <= '0;
      count_q <= '0;
    end else begin
      if (fire)      res_q   <= narrowed;
      if (out_wr_en) count_q <= count_q + 1'b1;
    end
  end

  assign out_data     = res_q;
  assign result_count = count_q;

endmodule

// File: rtl/vectorops_top.sv
// N-channel element-wise vector engine: NUM_IN input FIFOs, core, output FIFO.
// Build option: VECTOROPS_SAT_EN (see vectorops_core).
module vectorops_top
  import vectorops_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned FIFO_BUFFER_SIZE = 32,
  parameter int unsigned NUM_IN           = 3,
  parameter int unsigned COUNT_WIDTH      = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_wr_en,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_din,
  output logic [NUM_IN-1:0]            in_full,
  input  logic [1:0]                   mode,
  input  logic                         out_rd_en,
  output logic                         out_empty,
  output logic [DATA_WIDTH-1:0]        out_dout,
  output logic [COUNT_WIDTH-1:0]       result_count
);

  logic [NUM_IN-1:0]            in_empty, in_rd_en;
  logic [NUM_IN*DATA_WIDTH-1:0] in_head;
  logic                         out_full, out_wr_en;
  logic [DATA_WIDTH-1:0]        out_data;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in_fifo
    fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_BUFFER_SIZE)
    ) u_in_fifo (
      .clock (clock),
      .reset (reset),
      .wr_en (in_wr_en[k]),
      .din   (in_din[k*DATA_WIDTH +: DATA_WIDTH]),
      .full  (in_full[k]),
      .rd_en (in_rd_en[k]),
      .dout  (in_head[k*DATA_WIDTH +: DATA_WIDTH]),
      .empty (in_empty[k])
    );
  end

  vectorops_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_IN      (NUM_IN),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_core (
    .clock        (clock),
    .reset        (reset),
    .in_empty     (in_empty),
    .in_data      (in_head),
    .in_rd_en     (in_rd_en),
    .mode         (mode),
    .out_full     (out_full),
    .out_wr_en    (out_wr_en),
    .out_data     (out_data),
    .result_count (result_count)
  );

  fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_BUFFER_SIZE)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (out_wr_en),
    .din   (out_data),
    .full  (out_full),
    .rd_en (out_rd_en),
    .dout  (out_dout),
    .empty (out_empty)
  );

endmodule

// File: tb/tb_vectorops_top.sv
// Self-checking bench for vectorops_top (DATA_WIDTH = 32, NUM_IN = 3).
module tb_vectorops_top;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  in_wr_en;
  logic [95:0] in_din;
  logic [2:0]  in_full;
  logic [1:0]  mode;
  logic        out_rd_en;
  logic        out_empty;
  logic [31:0] out_dout;
  logic [31:0] result_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  int base;
  logic [31:0] q0[$], q1[$], q2[$], exp_q[$];
  logic [31:0] ovf_sum, ovf_sub;

  vectorops_top #(
    .DATA_WIDTH       (32),
    .FIFO_BUFFER_SIZE (32),
    .NUM_IN           (3),
    .COUNT_WIDTH      (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_wr_en     (in_wr_en),
    .in_din       (in_din),
    .in_full      (in_full),
    .mode         (mode),
    .out_rd_en    (out_rd_en),
    .out_empty    (out_empty),
    .out_dout     (out_dout),
    .result_count (result_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, then wrap or clamp to 32 bits.
  function automatic logic [31:0] ref_op(input logic [1:0] m, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
    longint x, y, z, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    z = longint'($signed(c));
    if (m == 2'b01) r = x - y - z;
    else if (m == 2'b10) begin
      r = x;
      if (y > r) r = y;
      if (z > r) r = z;
    end else r = x + y + z;
`ifdef VECTOROPS_SAT_EN
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
    return 32'(r);
  endfunction

  task automatic settle();
    while (q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
      exp_q.push_back(ref_op(mode, q0.pop_front(), q1.pop_front(), q2.pop_front()));
      exp_count++;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [2:0] en, input bit model);
    in_din   = {c, b, a};
    in_wr_en = en;
    @(posedge clock);
    #1;
    in_wr_en = 3'b000;
    if (model) begin
      if (en[0]) q0.push_back(a);
      if (en[1]) q1.push_back(b);
      if (en[2]) q2.push_back(c);
      settle();
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    int t = 0;
    while (out_empty && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (out_empty) begin
      check({tag, "_timeout"}, 64'(out_empty), 64'd0);
      return;
    end
    check(tag, 64'(out_dout), 64'(exp));
    out_rd_en = 1'b1;
    @(posedge clock);
    #1;
    out_rd_en = 1'b0;
  endtask

  task automatic drain_model(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_model_empty"}, 64'd0, 64'd1);
        return;
      end
      pop_check(tag, exp_q.pop_front());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_wr_en  = 3'b000;
    in_din    = '0;
    mode      = 2'b00;
    out_rd_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_full", 64'(in_full), 64'd0);
    check("rst_out_empty", 64'(out_empty), 64'd1);
    check("rst_out_dout", 64'(out_dout), 64'd0);
    check("rst_count", 64'(result_count), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed arithmetic cases
    mode = 2'b00; push(1, 2, 3, 3'b111, 0); exp_count++;
    pop_check("sum", 6);
    check("sum_count", 64'(result_count), 64'd1);
    mode = 2'b01; push(10, 3, 4, 3'b111, 0); exp_count++;
    pop_check("sub", 3);
    mode = 2'b10; push(32'(-5), 7, 2, 3'b111, 0); exp_count++;
    pop_check("max_pos", 7);
    push(32'(-5), 32'(-7), 32'(-2), 3'b111, 0); exp_count++;
    pop_check("max_neg", 32'(-2));
`ifdef VECTOROPS_SAT_EN
    ovf_sum = 32'h7FFF_FFFF;
    ovf_sub = 32'h8000_0000;
`else
    ovf_sum = 32'h8000_0000;
    ovf_sub = 32'h7FFF_FFFF;
`endif
    mode = 2'b00; push(32'h7FFF_FFFF, 1, 0, 3'b111, 0); exp_count++;
    pop_check("ovf_sum", ovf_sum);
    mode = 2'b01; push(32'h8000_0000, 1, 0, 3'b111, 0); exp_count++;
    pop_check("ovf_sub", ovf_sub);
    mode = 2'b11; push(5, 6, 7, 3'b111, 0); exp_count++;
    pop_check("reserved_sum", 18);
    check("directed_count", 64'(result_count), 64'(exp_count));

    // Randomised batches against the reference model
    for (int b = 0; b < 6; b++) begin
      mode = 2'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1)
          push($urandom, $urandom, $urandom, 3'b111, 1);
        else
          push(32'($urandom_range(0, 200)) - 32'd100, 32'($urandom_range(0, 200)) - 32'd100,
               32'($urandom_range(0, 200)) - 32'd100, 3'b111, 1);
      end
      drain_model(8, "rand");
    end
    check("rand_count", 64'(result_count), 64'(exp_count));

    // Back-pressure: out FIFO holds 32, core register holds one more
    mode = 2'b00;
    base = exp_count;
    for (int k = 0; k < 40; k++) push(k, k, k, 3'b111, 1);
    repeat (10) @(posedge clock);
    #1;
    check("bp_stall_count", 64'(result_count), 64'(base + 32));
    check("bp_in_not_full", 64'(in_full), 64'd0);
    check("bp_out_nonempty", 64'(out_empty), 64'd0);
    for (int k = 40; k < 65; k++) push(k, k, k, 3'b111, 1);
    #1;
    check("bp_in_full", 64'(in_full), 64'd7);
    push(65, 65, 65, 3'b111, 0);
    repeat (3) @(posedge clock);
    #1;
    check("bp_still_stalled", 64'(result_count), 64'(base + 32));
    drain_model(65, "bp_order");
    repeat (5) @(posedge clock);
    #1;
    check("bp_drained", 64'(out_empty), 64'd1);
    check("bp_count", 64'(result_count), 64'(exp_count));

    // Skewed arrivals
    for (int i = 0; i < 5; i++) push($urandom, 0, 0, 3'b001, 1);
    repeat (10) @(posedge clock);
    #1;
    check("skew_hold", 64'(out_empty), 64'd1);
    check("skew_hold_count", 64'(result_count), 64'(exp_count));
    for (int i = 0; i < 5; i++) push(0, $urandom, $urandom, 3'b110, 1);
    drain_model(5, "skew_pair");
    check("skew_count", 64'(result_count), 64'(exp_count));

    // Reset mid-stream
    for (int i = 0; i < 10; i++) push(i, i + 1, i + 2, 3'b111, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete(); q0.delete(); q1.delete(); q2.delete();
    exp_count = 0;
    check("mid_rst_in_full", 64'(in_full), 64'd0);
    check("mid_rst_out_empty", 64'(out_empty), 64'd1);
    check("mid_rst_out_dout", 64'(out_dout), 64'd0);
    check("mid_rst_count", 64'(result_count), 64'd0);
    repeat (5) @(posedge clock);
    #1;
    check("mid_rst_idle", 64'(out_empty), 64'd1);
    mode = 2'b00;
    push(4, 5, 6, 3'b111, 1);
    drain_model(1, "post_rst");
    repeat (5) @(posedge clock);
    #1;
    check("post_rst_empty", 64'(out_empty), 64'd1);
    check("post_rst_count", 64'(result_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
